jtag_tap_ctrl: RTL and testbench
================================

JTAG_TAP_CTRL -- requirements
Module: jtag_tap_ctrl

Interface
REQ-001 The block SHALL have parameter IR_W, default 4, giving the instruction register width.
REQ-002 The block SHALL have parameter DR_W, default 8, giving the user data register width.
REQ-003 The block SHALL have parameter IDCODE_VAL, default 32'h1000_0001, giving the device ID; bit 0 is always 1.
REQ-004 The block SHALL have port tck, input, 1 bit: the only clock.
REQ-005 The block SHALL have port trst, input, 1 bit: asynchronous active-low reset.
REQ-006 The block SHALL have port tms, input, 1 bit: test mode select, sampled on posedge tck.
REQ-007 The block SHALL have port tdi, input, 1 bit: serial data in, sampled on posedge tck.
REQ-008 The block SHALL have port tdo, output, 1 bit: serial data out, changing on negedge tck.
REQ-009 The block SHALL have port tdo_en, output, 1 bit: high while tdo carries valid shift data.
REQ-010 The block SHALL have port user_dr_in, input, DR_W bits: value captured into the user register in Capture-DR.
REQ-011 The block SHALL have port user_dr_out, output, DR_W bits: last updated user register value.
REQ-012 The block SHALL have port user_update, output, 1 bit: one-tck pulse when user_dr_out is loaded.
REQ-013 The block SHALL have port tap_state, output, 4 bits: current TAP state encoding.

Function
REQ-014 The block SHALL implement the 16-state IEEE 1149.1 TAP FSM, advancing on posedge tck per tms, with these encodings:
- TLR=F, RTI=C, SelDR=7, CapDR=6, ShDR=2, Ex1DR=1, PauseDR=3, Ex2DR=0, UpdDR=5
- SelIR=4, CapIR=E, ShIR=A, Ex1IR=9, PauseIR=B, Ex2IR=8, UpdIR=D
REQ-015 The block SHALL reach TLR from any state after five consecutive posedges with tms=1.
REQ-016 In CapIR, the block SHALL load the IR shift register with IR_W'b0…01.
REQ-017 In ShIR, the block SHALL shift the IR shift register right, with tdi entering at the MSB and the LSB feeding tdo.
REQ-018 On the posedge taken while in UpdIR, the block SHALL copy the IR shift register to the active IR.
REQ-019 The block SHALL decode the active IR as follows:
- 4'b0001 = IDCODE
- 4'b0010 = USER
- 4'b1111 = BYPASS
- any other value = BYPASS
REQ-020 In CapDR, the block SHALL load the selected DR: BYPASS with 0, IDCODE with IDCODE_VAL, USER with user_dr_in.
REQ-021 In ShDR, the block SHALL shift the selected DR right, with tdi entering at the MSB and the LSB feeding tdo; BYPASS is a one-bit path.
REQ-022 On the posedge taken while in UpdDR with IR=USER, the block SHALL load user_dr_out from the user shift register and assert user_update for exactly one tck cycle.
REQ-023 For all other instructions, UpdDR SHALL leave user_dr_out unchanged and user_update low.
REQ-024 On negedge tck, the block SHALL register tdo from the current shift-register LSB and set tdo_en=1 iff the state is ShDR or ShIR; otherwise tdo=0 and tdo_en=0.
REQ-025 The block SHALL hold shift register contents through Pause and Exit states, with no shifting.
REQ-026 Every state transition SHALL occur regardless of the IR value.
REQ-027 Entering TLR by tms SHALL reset the active IR to the reset instruction (REQ-030), with the same effect as trst except that user_dr_out is retained.

Reset
REQ-028 While trst=0, the block SHALL asynchronously force:
- tap_state=TLR (4'hF)
- active IR = reset instruction
- all shift registers = 0
- tdo=0, tdo_en=0
- user_dr_out=0, user_update=0
REQ-029 An assertion of trst in the middle of a shift SHALL abort the shift with no update, and the FSM SHALL resume from TLR on the first posedge after trst deasserts.

Configuration
REQ-030 With JTAG_IDCODE_EN defined, the block SHALL include the 32-bit IDCODE register, and the reset instruction SHALL be IDCODE.
REQ-031 With JTAG_IDCODE_EN undefined, the block SHALL omit the IDCODE register, decode 4'b0001 as BYPASS, and use BYPASS as the reset instruction.

Structure
REQ-032 Package jtag_pkg SHALL hold the tap_state_e enum (REQ-014 encodings) and the instruction opcode constants.
REQ-033 The 16-state FSM SHALL be a separate sub-module, jtag_tap_fsm (inputs tck, trst, tms; output state), instantiated by jtag_tap_ctrl.

Verification
REQ-034 The bench SHALL drive the FSM to ShDR, then apply tms=1 for 5 cycles, and check tap_state=4'hF.
REQ-035 With JTAG_IDCODE_EN defined, the bench SHALL pulse trst, go to ShDR, and shift 32 bits, checking that tdo yields 32'h1000_0001 LSB-first.
REQ-036 The bench SHALL load IR=4'b1111, shift tdi pattern 1,0,1,1 in ShDR, and check that tdo shows 0 (the captured bypass bit) followed by 1,0,1, delayed one bit.
REQ-037 The bench SHALL shift IR with tdi=0 and check that the first 4 tdo bits are 1,0,0,0 (capture value 4'b0001).
REQ-038 The bench SHALL load IR=4'b0010 with user_dr_in=8'h3C, shift in 8'hA5, and pass through UpdDR, checking that:
- tdo yields 8'h3C LSB-first
- user_dr_out=8'hA5
- user_update is high for one cycle
REQ-039 The bench SHALL assert trst after 4 bits of an 8-bit USER shift and check that tap_state=4'hF, user_dr_out=0, user_update never pulsed, and tdo_en=0.

Source files
------------

// File: rtl/jtag_pkg.sv
// Shared TAP state encodings and instruction opcodes.
// The IDCODE register is built only when JTAG_IDCODE_EN is defined.
package jtag_pkg;

    typedef enum logic [3:0] {
        TLR      = 4'hF,
        RTI      = 4'hC,
        SEL_DR   = 4'h7,
        CAP_DR   = 4'h6,
        SH_DR    = 4'h2,
        EX1_DR   = 4'h1,
        PAUSE_DR = 4'h3,
        EX2_DR   = 4'h0,
        UPD_DR   = 4'h5,
        SEL_IR   = 4'h4,
        CAP_IR   = 4'hE,
        SH_IR    = 4'hA,
        EX1_IR   = 4'h9,
        PAUSE_IR = 4'hB,
        EX2_IR   = 4'h8,
        UPD_IR   = 4'hD
    } tap_state_e;

    localparam logic [3:0] OP_IDCODE = 4'b0001;
    localparam logic [3:0] OP_USER   = 4'b0010;
    localparam logic [3:0] OP_BYPASS = 4'b1111;

    function automatic logic is_shift(tap_state_e s);
        return (s == SH_DR) || (s == SH_IR);
    endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// 16-state IEEE 1149.1 TAP controller, advanced by tms on posedge tck.
// Asynchronous active-low trst forces Test-Logic-Reset.
module jtag_tap_fsm
    import jtag_pkg::*;
(
    input  logic       tck,
    input  logic       trst,
    input  logic       tms,
    output tap_state_e state
);

    always_ff @(posedge tck or negedge trst) begin
        if (!trst) begin
            state <= TLR;
        end else begin
            unique case (state)
                TLR:      state <= tms ? TLR    : RTI;
                RTI:      state <= tms ? SEL_DR : RTI;
                SEL_DR:   state <= tms ? SEL_IR : CAP_DR;
                CAP_DR:   state <= tms ? EX1_DR : SH_DR;
                SH_DR:    state <= tms ? EX1_DR : SH_DR;
                EX1_DR:   state <= tms ? UPD_DR : PAUSE_DR;
                PAUSE_DR: state <= tms ? EX2_DR : PAUSE_DR;
                EX2_DR:   state <= tms ? UPD_DR : SH_DR;
                UPD_DR:   state <= tms ? SEL_DR : RTI;
                SEL_IR:   state <= tms ? TLR    : CAP_IR;
                CAP_IR:   state <= tms ? EX1_IR : SH_IR;
                SH_IR:    state <= tms ? EX1_IR : SH_IR;
                EX1_IR:   state <= tms ? UPD_IR : PAUSE_IR;
                PAUSE_IR: state <= tms ? EX2_IR : PAUSE_IR;
                EX2_IR:   state <= tms ? UPD_IR : SH_IR;
                UPD_IR:   state <= tms ? SEL_DR : RTI;
            endcase
        end
    end

endmodule

// File: rtl/jtag_tap_ctrl.sv
// JTAG TAP with IR, BYPASS, USER and optional IDCODE data registers.
// Define JTAG_IDCODE_EN to build IDCODE and make it the reset instruction.
module jtag_tap_ctrl
    import jtag_pkg::*;
#(
    parameter int          IR_W       = 4,
    parameter int          DR_W       = 8,
    parameter logic [31:0] IDCODE_VAL = 32'h1000_0001
) (
    input  logic            tck,
    input  logic            trst,
    input  logic            tms,
    input  logic            tdi,
    output logic            tdo,
    output logic            tdo_en,
    input  logic [DR_W-1:0] user_dr_in,
    output logic [DR_W-1:0] user_dr_out,
    output logic            user_update,
    output logic [3:0]      tap_state
);

    localparam logic [IR_W-1:0] IR_IDCODE = IR_W'(OP_IDCODE);
    localparam logic [IR_W-1:0] IR_USER   = IR_W'(OP_USER);
    localparam logic [IR_W-1:0] IR_BYPASS = IR_W'(OP_BYPASS);
`ifdef JTAG_IDCODE_EN
    localparam logic [IR_W-1:0] IR_RESET  = IR_IDCODE;
`else
    localparam logic [IR_W-1:0] IR_RESET  = IR_BYPASS;
`endif

    tap_state_e      state;
    logic [IR_W-1:0] ir;
    logic [IR_W-1:0] ir_sr;
    logic [DR_W-1:0] user_sr;
    logic            bypass_sr;
    logic            sel_user;
    logic            sel_bypass;
    logic            dr_lsb;
    logic            shift_lsb;
`ifdef JTAG_IDCODE_EN
    logic [31:0]     idcode_sr;
    logic            sel_idcode;
`else
    logic            unused_cfg;
    assign unused_cfg = ^{IDCODE_VAL, IR_IDCODE};
`endif

    jtag_tap_fsm u_fsm (
        .tck   (tck),
        .trst  (trst),
        .tms   (tms),
        .state (state)
    );

    assign tap_state = state;

    always_comb begin
        sel_user   = (ir == IR_USER);
`ifdef JTAG_IDCODE_EN
        sel_idcode = (ir == IR_IDCODE);
        sel_bypass = !sel_user && !sel_idcode;
`else
        sel_bypass = !sel_user;
`endif
    end

    always_comb begin
        dr_lsb = bypass_sr;
        unique case (1'b1)
            sel_user:   dr_lsb = user_sr[0];
`ifdef JTAG_IDCODE_EN
            sel_idcode: dr_lsb = idcode_sr[0];
`endif
            default:    dr_lsb = bypass_sr;
        endcase
        shift_lsb = (state == SH_IR) ? ir_sr[0] : dr_lsb;
    end

    always_ff @(posedge tck or negedge trst) begin
        if (!trst) begin
            ir          <= IR_RESET;
            ir_sr       <= '0;
            user_sr     <= '0;
            bypass_sr   <= 1'b0;
            user_dr_out <= '0;
            user_update <= 1'b0;
`ifdef JTAG_IDCODE_EN
            idcode_sr   <= '0;
`endif
        end else begin
            user_update <= 1'b0;
            unique case (state)
                // Soft reset via tms keeps the last user_dr_out
                TLR: begin
                    ir        <= IR_RESET;
                    ir_sr     <= '0;
                    user_sr   <= '0;
                    bypass_sr <= 1'b0;
`ifdef JTAG_IDCODE_EN
                    idcode_sr <= '0;
`endif
                end
                CAP_IR: ir_sr <= IR_W'(1);
                SH_IR:  ir_sr <= {tdi, ir_sr[IR_W-1:1]};
                UPD_IR: ir    <= ir_sr;
                CAP_DR: begin
                    bypass_sr <= 1'b0;
                    if (sel_user) user_sr <= user_dr_in;
`ifdef JTAG_IDCODE_EN
                    if (sel_idcode) idcode_sr <= {IDCODE_VAL[31:1], 1'b1};
`endif
                end
                SH_DR: begin
                    if (sel_bypass) bypass_sr <= tdi;
                    if (sel_user) user_sr <= {tdi, user_sr[DR_W-1:1]};
`ifdef JTAG_IDCODE_EN
                    if (sel_idcode) idcode_sr <= {tdi, idcode_sr[31:1]};
`endif
                end
                UPD_DR: begin
                    if (sel_user) begin
                        user_dr_out <= user_sr;
                        user_update <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(negedge tck or negedge trst) begin
        if (!trst) begin
            tdo    <= 1'b0;
            tdo_en <= 1'b0;
        end else begin
            tdo_en <= is_shift(state);
            tdo    <= is_shift(state) ? shift_lsb : 1'b0;
        end
    end

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Randomized self-checking bench for jtag_tap_ctrl.
// Uses a transition-table TAP model and bit-stream data model.
module tb_jtag_tap_ctrl;

    localparam logic [31:0] IDC = 32'h1000_0001;

    logic       tck = 1'b0;
    logic       trst;
    logic       tms;
    logic       tdi;
    logic       tdo;
    logic       tdo_en;
    logic [7:0] user_dr_in;
    logic [7:0] user_dr_out;
    logic       user_update;
    logic [3:0] tap_state;

    jtag_tap_ctrl #(
        .IR_W       (4),
        .DR_W       (8),
        .IDCODE_VAL (IDC)
    ) dut (
        .tck         (tck),
        .trst        (trst),
        .tms         (tms),
        .tdi         (tdi),
        .tdo         (tdo),
        .tdo_en      (tdo_en),
        .user_dr_in  (user_dr_in),
        .user_dr_out (user_dr_out),
        .user_update (user_update),
        .tap_state   (tap_state)
    );

    always #5 tck = ~tck;

    int checks = 0;
    int errors = 0;
    int upd_cycles = 0;

    logic [3:0] m_state;
    logic       last_tdo;
    logic       last_en;
    logic [3:0] nxt0 [0:15];
    logic [3:0] nxt1 [0:15];

    always @(negedge tck) begin
        if (user_update === 1'b1) upd_cycles <= upd_cycles + 1;
    end

    function automatic logic [3:0] nxt(input logic [3:0] s, input logic t);
        return t ? nxt1[s] : nxt0[s];
    endfunction

    task automatic step(input logic t, input logic d);
        logic exp_en;
        tms = t;
        tdi = d;
        @(posedge tck);
        #1;
        m_state = nxt(m_state, t);
        checks++;
        if (tap_state !== m_state) begin
            errors++;
            $display("FAIL step_state: got %h expected %h", tap_state, m_state);
        end
        @(negedge tck);
        #1;
        last_tdo = tdo;
        last_en  = tdo_en;
        exp_en   = (m_state == 4'h2) || (m_state == 4'hA);
        checks++;
        if (tdo_en !== exp_en) begin
            errors++;
            $display("FAIL step_tdo_en: got %b expected %b in state %h", tdo_en, exp_en, m_state);
        end
        if (!exp_en) begin
            checks++;
            if (tdo !== 1'b0) begin
                errors++;
                $display("FAIL step_tdo_idle: got %b expected 0", tdo);
            end
        end
    endtask

    task automatic pulse_trst();
        trst = 1'b0;
        #2;
        @(negedge tck);
        #1;
        trst     = 1'b1;
        m_state  = 4'hF;
        last_tdo = 1'b0;
        last_en  = 1'b0;
        step(1'b0, 1'b0);
    endtask

    // From RTI: scan the IR, return the captured bits, end in RTI
    task automatic load_ir(input logic [3:0] v, output logic [3:0] cap);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cap[i] = last_tdo;
            step(1'(i == 3), v[i]);
        end
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
    endtask

    // From RTI: scan n DR bits with optional pause, end in RTI
    task automatic dr_scan(input int n, input logic [31:0] din,
                           input int pause_at, output logic [31:0] dout);
        dout = '0;
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        for (int i = 0; i < n; i++) begin
            dout[i] = last_tdo;
            step(1'((i == n - 1) || (i == pause_at)), din[i]);
            if (i == pause_at && i != n - 1) begin
                step(1'b0, 1'b0);
                step(1'b0, 1'b0);
                step(1'b1, 1'b0);
                step(1'b0, 1'b0);
            end
        end
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
    endtask

    function automatic logic [31:0] nmask(input int n);
        return (n >= 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
    endfunction

    task automatic test_reset();
        repeat (2) @(negedge tck);
        #1;
        checks++;
        if (tap_state !== 4'hF) begin
            errors++;
            $display("FAIL reset_state: got %h expected f", tap_state);
        end
        checks++;
        if (tdo !== 1'b0 || tdo_en !== 1'b0) begin
            errors++;
            $display("FAIL reset_tdo: got %b/%b expected 0/0", tdo, tdo_en);
        end
        checks++;
        if (user_dr_out !== 8'h00 || user_update !== 1'b0) begin
            errors++;
            $display("FAIL reset_user: got %h/%b expected 00/0", user_dr_out, user_update);
        end
        trst = 1'b1;
        step(1'b0, 1'b0);
    endtask

    task automatic test_random_walk();
        for (int k = 0; k < 20; k++) begin
            int len;
            len = $urandom_range(1, 25);
            for (int j = 0; j < len; j++)
                step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            repeat (5) step(1'b1, 1'($urandom_range(0, 1)));
            checks++;
            if (tap_state !== 4'hF) begin
                errors++;
                $display("FAIL walk_tlr: got %h expected f", tap_state);
            end
        end
        step(1'b0, 1'b0);
    endtask

    task automatic test_tlr_from_shdr();
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        checks++;
        if (tap_state !== 4'h2) begin
            errors++;
            $display("FAIL shdr_reach: got %h expected 2", tap_state);
        end
        repeat (5) step(1'b1, 1'b0);
        checks++;
        if (tap_state !== 4'hF) begin
            errors++;
            $display("FAIL shdr_to_tlr: got %h expected f", tap_state);
        end
        step(1'b0, 1'b0);
    endtask

    task automatic test_ir_capture();
        logic [3:0]  cap;
        logic [31:0] din;
        logic [31:0] dout;
        load_ir(4'b0000, cap);
        checks++;
        if (cap !== 4'b0001) begin
            errors++;
            $display("FAIL ir_capture: got %b expected 0001", cap);
        end
        din = $urandom;
        dr_scan(4, din, -1, dout);
        checks++;
        if (dout[3:0] !== {din[2:0], 1'b0}) begin
            errors++;
            $display("FAIL ir0_bypass: got %b expected %b", dout[3:0], {din[2:0], 1'b0});
        end
    endtask

    task automatic test_bypass();
        logic [3:0]  cap;
        logic [31:0] dout;
        logic [7:0]  keep;
        int          u0;
        load_ir(4'b1111, cap);
        keep = user_dr_out;
        u0   = upd_cycles;
        dr_scan(4, 32'b1101, -1, dout);
        checks++;
        if (dout[3:0] !== 4'b1010) begin
            errors++;
            $display("FAIL bypass_tdo: got %b expected 1010", dout[3:0]);
        end
        checks++;
        if (user_dr_out !== keep || upd_cycles != u0) begin
            errors++;
            $display("FAIL bypass_no_upd: got %h/%0d expected %h/0", user_dr_out, upd_cycles - u0, keep);
        end
    endtask

    task automatic test_reset_instr();
        logic [3:0]  cap;
        logic [31:0] din;
        logic [31:0] dout;
        pulse_trst();
`ifdef JTAG_IDCODE_EN
        din = $urandom;
        dr_scan(32, din, -1, dout);
        checks++;
        if (dout !== IDC) begin
            errors++;
            $display("FAIL idcode_reset: got %h expected %h", dout, IDC);
        end
        load_ir(4'b0001, cap);
        dr_scan(32, din, 7, dout);
        checks++;
        if (dout !== IDC) begin
            errors++;
            $display("FAIL idcode_ir: got %h expected %h", dout, IDC);
        end
`else
        din = $urandom;
        dr_scan(8, din, -1, dout);
        checks++;
        if (dout[7:0] !== {din[6:0], 1'b0}) begin
            errors++;
            $display("FAIL reset_bypass: got %h expected %h", dout[7:0], {din[6:0], 1'b0});
        end
        load_ir(4'b0001, cap);
        din = $urandom;
        dr_scan(8, din, -1, dout);
        checks++;
        if (dout[7:0] !== {din[6:0], 1'b0}) begin
            errors++;
            $display("FAIL op1_bypass: got %h expected %h", dout[7:0], {din[6:0], 1'b0});
        end
`endif
    endtask

    task automatic test_user();
        logic [3:0]  cap;
        logic [31:0] dout;
        int          u0;
        user_dr_in = 8'h3C;
        load_ir(4'b0010, cap);
        u0 = upd_cycles;
        dr_scan(8, 32'hA5, -1, dout);
        checks++;
        if (dout[7:0] !== 8'h3C) begin
            errors++;
            $display("FAIL user_tdo: got %h expected 3c", dout[7:0]);
        end
        checks++;
        if (user_dr_out !== 8'hA5) begin
            errors++;
            $display("FAIL user_out: got %h expected a5", user_dr_out);
        end
        checks++;
        if (upd_cycles - u0 != 1) begin
            errors++;
            $display("FAIL user_pulse: got %0d cycles expected 1", upd_cycles - u0);
        end
    endtask

    task automatic test_user_random();
        logic [3:0]  cap;
        logic [31:0] din;
        logic [31:0] dout;
        logic [63:0] s;
        int          n;
        int          p;
        int          u0;
        for (int k = 0; k < 8; k++) begin
            user_dr_in = 8'($urandom);
            din = $urandom;
            n   = $urandom_range(8, 12);
            p   = $urandom_range(0, 1) ? $urandom_range(0, n - 2) : -1;
            load_ir(4'b0010, cap);
            s  = ({32'b0, din} << 8) | {56'b0, user_dr_in};
            u0 = upd_cycles;
            dr_scan(n, din, p, dout);
            checks++;
            if (dout !== (s[31:0] & nmask(n))) begin
                errors++;
                $display("FAIL urand_tdo: got %h expected %h", dout, s[31:0] & nmask(n));
            end
            checks++;
            if (user_dr_out !== s[n +: 8]) begin
                errors++;
                $display("FAIL urand_out: got %h expected %h", user_dr_out, s[n +: 8]);
            end
            checks++;
            if (upd_cycles - u0 != 1) begin
                errors++;
                $display("FAIL urand_pulse: got %0d expected 1", upd_cycles - u0);
            end
        end
    endtask

    task automatic test_other_ir_no_update();
        logic [3:0]  ops [0:4];
        logic [3:0]  cap;
        logic [31:0] din;
        logic [31:0] dout;
        logic [7:0]  keep;
        int          u0;
        ops = '{4'b0000, 4'b0011, 4'b0111, 4'b1010, 4'b1111};
        for (int k = 0; k < 5; k++) begin
            user_dr_in = 8'($urandom);
            load_ir(ops[k], cap);
            din  = $urandom;
            keep = user_dr_out;
            u0   = upd_cycles;
            dr_scan(6, din, -1, dout);
            checks++;
            if (dout[5:0] !== {din[4:0], 1'b0}) begin
                errors++;
                $display("FAIL other_tdo: got %h expected %h", dout[5:0], {din[4:0], 1'b0});
            end
            checks++;
            if (user_dr_out !== keep || upd_cycles != u0) begin
                errors++;
                $display("FAIL other_no_upd: got %h/%0d expected %h/0", user_dr_out, upd_cycles - u0, keep);
            end
        end
    endtask

    task automatic test_tms_reset_ir();
        logic [3:0]  cap;
        logic [31:0] din;
        logic [31:0] dout;
        logic [63:0] s;
        logic [7:0]  v;
        int          u0;
        v = 8'($urandom);
        user_dr_in = 8'($urandom);
        load_ir(4'b0010, cap);
        dr_scan(8, {24'b0, v}, -1, dout);
        repeat (5) step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        din = $urandom;
        u0  = upd_cycles;
        dr_scan(8, din, -1, dout);
`ifdef JTAG_IDCODE_EN
        s = ({32'b0, din} << 32) | {32'b0, IDC};
`else
        s = {32'b0, din} << 1;
`endif
        checks++;
        if (dout[7:0] !== s[7:0]) begin
            errors++;
            $display("FAIL tms_reset_ir: got %h expected %h", dout[7:0], s[7:0]);
        end
        checks++;
        if (user_dr_out !== v || upd_cycles != u0) begin
            errors++;
            $display("FAIL tms_keep_user: got %h/%0d expected %h/0", user_dr_out, upd_cycles - u0, v);
        end
    endtask

    task automatic test_trst_abort();
        logic [3:0]  cap;
        logic [31:0] dout;
        int          u0;
        user_dr_in = 8'($urandom);
        load_ir(4'b0010, cap);
        dr_scan(8, 32'h5A, -1, dout);
        checks++;
        if (user_dr_out !== 8'h5A) begin
            errors++;
            $display("FAIL abort_setup: got %h expected 5a", user_dr_out);
        end
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'($urandom_range(0, 1)));
        u0   = upd_cycles;
        trst = 1'b0;
        #2;
        checks++;
        if (tap_state !== 4'hF || tdo_en !== 1'b0 || tdo !== 1'b0) begin
            errors++;
            $display("FAIL abort_state: got %h/%b/%b expected f/0/0", tap_state, tdo_en, tdo);
        end
        checks++;
        if (user_dr_out !== 8'h00) begin
            errors++;
            $display("FAIL abort_user: got %h expected 00", user_dr_out);
        end
        repeat (2) @(negedge tck);
        #1;
        checks++;
        if (upd_cycles != u0 || user_update !== 1'b0 || tap_state !== 4'hF) begin
            errors++;
            $display("FAIL abort_hold: got %0d/%b/%h expected 0/0/f", upd_cycles - u0, user_update, tap_state);
        end
        trst     = 1'b1;
        m_state  = 4'hF;
        last_tdo = 1'b0;
        last_en  = 1'b0;
        step(1'b0, 1'b0);
        checks++;
        if (tap_state !== 4'hC || user_dr_out !== 8'h00) begin
            errors++;
            $display("FAIL abort_resume: got %h/%h expected c/00", tap_state, user_dr_out);
        end
    endtask

    initial begin
        nxt0 = '{4'h2, 4'h3, 4'h2, 4'h3, 4'hE, 4'hC, 4'h2, 4'h6,
                 4'hA, 4'hB, 4'hA, 4'hB, 4'hC, 4'hC, 4'hA, 4'hC};
        nxt1 = '{4'h5, 4'h5, 4'h1, 4'h0, 4'hF, 4'h7, 4'h1, 4'h4,
                 4'hD, 4'hD, 4'h9, 4'h8, 4'h7, 4'h7, 4'h9, 4'hF};
        trst       = 1'b0;
        tms        = 1'b1;
        tdi        = 1'b0;
        user_dr_in = 8'h00;
        m_state    = 4'hF;
        last_tdo   = 1'b0;
        last_en    = 1'b0;
        test_reset();
        test_random_walk();
        test_tlr_from_shdr();
        test_ir_capture();
        test_bypass();
        test_reset_instr();
        test_user();
        test_user_random();
        test_other_ir_no_update();
        test_tms_reset_ir();
        test_trst_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
